// File: rtl/mdu_seq_pkg.sv
// Shared opcodes, FSM encodings and helpers for the multiply/divide sequencer.
// Signed MULS/DIVS support is built only when MDU_SIGNED_EN is defined.
package mdu_seq_pkg;

   localparam logic [1:0] MDU_OP_MULU = 2'b00;
   localparam logic [1:0] MDU_OP_DIVU = 2'b01;
   localparam logic [1:0] MDU_OP_MULS = 2'b10;
   localparam logic [1:0] MDU_OP_DIVS = 2'b11;

   typedef enum logic [1:0] {
      MDU_ST_IDLE = 2'b00,
      MDU_ST_RUN  = 2'b01,
      MDU_ST_DONE = 2'b10
   } mdu_state_e;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[0];
   endfunction

   function automatic logic [15:0] neg16(input logic [15:0] v);
      return ~v + 16'd1;
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// One combinational step of the shift-add multiply or restoring divide.
// For divide, acc_o[0] is left clear and the quotient bit comes out on qbit_o.
module mdu_iter
   import mdu_seq_pkg::*;
(
   input  logic [1:0]  op_i,
   input  logic [31:0] acc_i,
   input  logic [15:0] opnd_i,
   output logic [31:0] acc_o,
   output logic        qbit_o
);

   logic [16:0] sum;
   logic [16:0] trial;
   logic        unused_op;

   assign unused_op = op_i[1];

   always_comb begin
      acc_o  = acc_i;
      qbit_o = 1'b0;
      sum    = 17'd0;
      trial  = 17'd0;
      if (op_is_div(op_i)) begin
         // remainder plus the bit about to shift in can reach 17 bits
         trial = acc_i[31:15] - {1'b0, opnd_i};
         if (!trial[16]) begin
            acc_o  = {trial[15:0], acc_i[14:0], 1'b0};
            qbit_o = 1'b1;
         end else begin
            acc_o = {acc_i[30:0], 1'b0};
         end
      end else begin
         sum = {1'b0, acc_i[31:16]}
             + (acc_i[0] ? {1'b0, opnd_i} : 17'd0);
         acc_o = {sum, acc_i[15:1]};
      end
   end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MUL/DIV sequencer beside EXE; stalls the pipe until done.
// Define MDU_SIGNED_EN to enable signed MULS/DIVS (else op[1] is ignored).
module mdu_seq
   import mdu_seq_pkg::*;
#(
   parameter int ITER = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] op1,
   input  logic [15:0] op2,
   input  logic [3:0]  wreg_addr_i,
   input  logic        flush,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic [15:0] result_lo,
   output logic [15:0] result_hi,
   output logic [3:0]  wreg_addr_o
);

   localparam logic [3:0] LAST = 4'(ITER - 1);

   mdu_state_e  state_q, state_d;
   logic [3:0]  cnt_q;
   logic [1:0]  op_q;
   logic [31:0] acc_q;
   logic [15:0] opnd_q;
   logic [3:0]  wreg_q;
   logic [15:0] res_lo_q, res_hi_q;

   logic        accept;
   logic        dz;
   logic [15:0] a_mag, b_mag;
   logic [31:0] iter_acc;
   logic        iter_q;
   logic [31:0] fin;

   assign dz     = op_is_div(op) & (op2 == 16'h0000);
   assign accept = (state_q == MDU_ST_IDLE) & start & ~flush;

`ifdef MDU_SIGNED_EN
   logic a_neg, b_neg;
   logic neg_lo_q, neg_hi_q;
   logic [31:0] prod_neg;

   assign a_neg = op[1] & op1[15];
   assign b_neg = op[1] & op2[15];
   assign a_mag = a_neg ? neg16(op1) : op1;
   assign b_mag = b_neg ? neg16(op2) : op2;
   assign prod_neg = ~acc_q + 32'd1;

   always_comb begin
      fin = acc_q;
      if (op_is_div(op_q)) begin
         fin[15:0]  = neg_lo_q ? neg16(acc_q[15:0]) : acc_q[15:0];
         fin[31:16] = neg_hi_q ? neg16(acc_q[31:16]) : acc_q[31:16];
      end else if (neg_lo_q) begin
         fin = prod_neg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
      end else if (accept) begin
         // divide-by-zero returns raw operands, so no sign fix-up
         neg_lo_q <= ~dz & (a_neg ^ b_neg);
         neg_hi_q <= ~dz & (op_is_div(op) ? a_neg : (a_neg ^ b_neg));
      end
   end
`else
   assign a_mag = op1;
   assign b_mag = op2;
   assign fin   = acc_q;
`endif

   mdu_iter u_iter (
      .op_i   (op_q),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .acc_o  (iter_acc),
      .qbit_o (iter_q)
   );

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      stall   = 1'b0;
      unique case (state_q)
         MDU_ST_IDLE: begin
            stall = start;
            if (accept)
               state_d = dz ? MDU_ST_DONE : MDU_ST_RUN;
         end
         MDU_ST_RUN: begin
            busy  = 1'b1;
            stall = 1'b1;
            if (flush)
               state_d = MDU_ST_IDLE;
            else if (cnt_q == LAST)
               state_d = MDU_ST_DONE;
         end
         MDU_ST_DONE: begin
            busy    = 1'b1;
            done    = ~flush;
            state_d = MDU_ST_IDLE;
         end
         default: state_d = MDU_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= MDU_ST_IDLE;
         cnt_q    <= 4'd0;
         op_q     <= MDU_OP_MULU;
         acc_q    <= 32'd0;
         opnd_q   <= 16'd0;
         wreg_q   <= 4'd0;
         res_lo_q <= 16'd0;
         res_hi_q <= 16'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= op;
            cnt_q  <= 4'd0;
            wreg_q <= wreg_addr_i;
            if (dz) begin
               acc_q  <= {op1, 16'hFFFF};
               opnd_q <= 16'd0;
            end else if (op_is_div(op)) begin
               acc_q  <= {16'd0, a_mag};
               opnd_q <= b_mag;
            end else begin
               acc_q  <= {16'd0, b_mag};
               opnd_q <= a_mag;
            end
         end else if (state_q == MDU_ST_RUN) begin
            acc_q <= iter_acc | {31'd0, iter_q};
            cnt_q <= cnt_q + 4'd1;
         end
         if (state_q == MDU_ST_DONE && !flush) begin
            res_lo_q <= fin[15:0];
            res_hi_q <= fin[31:16];
         end
      end
   end

   // final value is forwarded during DONE so write-back sees it that cycle
   assign result_lo   = done ? fin[15:0]  : res_lo_q;
   assign result_hi   = done ? fin[31:16] : res_hi_q;
   assign wreg_addr_o = wreg_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq.
// Expectations for MULS/DIVS follow whether MDU_SIGNED_EN is defined.
module tb_mdu_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [15:0] op1, op2;
   logic [3:0]  wreg_addr_i;
   logic        flush;
   logic        busy, stall, done;
   logic [15:0] result_lo, result_hi;
   logic [3:0]  wreg_addr_o;

   int total = 0;
   int bad   = 0;

   mdu_seq #(.ITER(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .op1         (op1),
      .op2         (op2),
      .wreg_addr_i (wreg_addr_i),
      .flush       (flush),
      .busy        (busy),
      .stall       (stall),
      .done        (done),
      .result_lo   (result_lo),
      .result_hi   (result_hi),
      .wreg_addr_o (wreg_addr_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request and reports what was seen; lat = -1 on timeout.
   task automatic do_op(input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] wa,
                        output int lat, output logic [15:0] lo,
                        output logic [15:0] hi, output logic [3:0] wo,
                        output logic st_pre, output int st_cnt,
                        output logic st_done);
      @(negedge clk);
      start = 1'b1; op = o; op1 = a; op2 = b; wreg_addr_i = wa;
      #1 st_pre = stall;
      @(posedge clk);
      #1 start = 1'b0;
      lat = -1; st_cnt = 0; st_done = 1'b1;
      lo = 16'hxxxx; hi = 16'hxxxx; wo = 4'hx;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k; lo = result_lo; hi = result_hi;
            wo = wreg_addr_o; st_done = stall;
            break;
         end
         if (stall) st_cnt++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total += 6;
      if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
      if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      if (result_lo !== 16'h0) begin bad++; $display("FAIL rst_lo got=%h exp=0000", result_lo); end
      if (result_hi !== 16'h0) begin bad++; $display("FAIL rst_hi got=%h exp=0000", result_hi); end
      if (wreg_addr_o !== 4'h0) begin bad++; $display("FAIL rst_wa got=%h exp=0", wreg_addr_o); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mulu;
      int lat, sc; logic [15:0] lo, hi; logic [3:0] wo; logic sp, sd;
      do_op(2'b00, 16'h1234, 16'h0010, 4'h5, lat, lo, hi, wo, sp, sc, sd);
      total += 7;
      if (lat !== 17) begin bad++; $display("FAIL mulu_lat got=%0d exp=17", lat); end
      if (hi !== 16'h0001) begin bad++; $display("FAIL mulu_hi got=%h exp=0001", hi); end
      if (lo !== 16'h2340) begin bad++; $display("FAIL mulu_lo got=%h exp=2340", lo); end
      if (wo !== 4'h5) begin bad++; $display("FAIL mulu_wa got=%h exp=5", wo); end
      if (sp !== 1'b1) begin bad++; $display("FAIL mulu_stall_pre got=%b exp=1", sp); end
      if (sc !== 16) begin bad++; $display("FAIL mulu_stall_cnt got=%0d exp=16", sc); end
      if (sd !== 1'b0) begin bad++; $display("FAIL mulu_stall_done got=%b exp=0", sd); end
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL mulu_busy_after got=%b exp=0", busy); end
      do_op(2'b00, 16'hFFFF, 16'hFFFF, 4'h1, lat, lo, hi, wo, sp, sc, sd);
      total += 2;
      if (hi !== 16'hFFFE) begin bad++; $display("FAIL mulmax_hi got=%h exp=fffe", hi); end
      if (lo !== 16'h0001) begin bad++; $display("FAIL mulmax_lo got=%h exp=0001", lo); end
   endtask

   task automatic test_divu;
      int lat, sc; logic [15:0] lo, hi; logic [3:0] wo; logic sp, sd;
      do_op(2'b01, 16'd100, 16'd7, 4'h9, lat, lo, hi, wo, sp, sc, sd);
      total += 4;
      if (lat !== 17) begin bad++; $display("FAIL divu_lat got=%0d exp=17", lat); end
      if (lo !== 16'h000E) begin bad++; $display("FAIL divu_lo got=%h exp=000e", lo); end
      if (hi !== 16'h0002) begin bad++; $display("FAIL divu_hi got=%h exp=0002", hi); end
      if (wo !== 4'h9) begin bad++; $display("FAIL divu_wa got=%h exp=9", wo); end
      do_op(2'b01, 16'hFFFF, 16'h0001, 4'h2, lat, lo, hi, wo, sp, sc, sd);
      total += 2;
      if (lo !== 16'hFFFF) begin bad++; $display("FAIL divbig_lo got=%h exp=ffff", lo); end
      if (hi !== 16'h0000) begin bad++; $display("FAIL divbig_hi got=%h exp=0000", hi); end
      do_op(2'b01, 16'hFFFE, 16'hFFFF, 4'h2, lat, lo, hi, wo, sp, sc, sd);
      total += 2;
      if (lo !== 16'h0000) begin bad++; $display("FAIL divsm_lo got=%h exp=0000", lo); end
      if (hi !== 16'hFFFE) begin bad++; $display("FAIL divsm_hi got=%h exp=fffe", hi); end
   endtask

   task automatic test_divzero;
      int lat, sc; logic [15:0] lo, hi; logic [3:0] wo; logic sp, sd;
      do_op(2'b01, 16'h0055, 16'h0000, 4'hC, lat, lo, hi, wo, sp, sc, sd);
      total += 5;
      if (lat !== 1) begin bad++; $display("FAIL dz_lat got=%0d exp=1", lat); end
      if (lo !== 16'hFFFF) begin bad++; $display("FAIL dz_lo got=%h exp=ffff", lo); end
      if (hi !== 16'h0055) begin bad++; $display("FAIL dz_hi got=%h exp=0055", hi); end
      if (wo !== 4'hC) begin bad++; $display("FAIL dz_wa got=%h exp=c", wo); end
      if (sc !== 0) begin bad++; $display("FAIL dz_stall_cnt got=%0d exp=0", sc); end
      do_op(2'b11, 16'h8001, 16'h0000, 4'hD, lat, lo, hi, wo, sp, sc, sd);
      total += 3;
      if (lat !== 1) begin bad++; $display("FAIL dzs_lat got=%0d exp=1", lat); end
      if (lo !== 16'hFFFF) begin bad++; $display("FAIL dzs_lo got=%h exp=ffff", lo); end
      if (hi !== 16'h8001) begin bad++; $display("FAIL dzs_hi got=%h exp=8001", hi); end
   endtask

   task automatic test_signed;
      int lat, sc; logic [15:0] lo, hi; logic [3:0] wo; logic sp, sd;
      logic [15:0] e_mh, e_dl, e_dh, e_bl, e_bh;
`ifdef MDU_SIGNED_EN
      e_mh = 16'hFFFF; e_dl = 16'hFFFD; e_dh = 16'hFFFF;
      e_bl = 16'h8000; e_bh = 16'h0000;
`else
      e_mh = 16'h0004; e_dl = 16'h7FFC; e_dh = 16'h0001;
      e_bl = 16'h0000; e_bh = 16'h8000;
`endif
      do_op(2'b10, 16'hFFFD, 16'h0005, 4'h3, lat, lo, hi, wo, sp, sc, sd);
      total += 2;
      if (hi !== e_mh) begin bad++; $display("FAIL muls_hi got=%h exp=%h", hi, e_mh); end
      if (lo !== 16'hFFF1) begin bad++; $display("FAIL muls_lo got=%h exp=fff1", lo); end
      do_op(2'b11, 16'hFFF9, 16'h0002, 4'h4, lat, lo, hi, wo, sp, sc, sd);
      total += 2;
      if (lo !== e_dl) begin bad++; $display("FAIL divs_lo got=%h exp=%h", lo, e_dl); end
      if (hi !== e_dh) begin bad++; $display("FAIL divs_hi got=%h exp=%h", hi, e_dh); end
      do_op(2'b11, 16'h8000, 16'hFFFF, 4'h4, lat, lo, hi, wo, sp, sc, sd);
      total += 2;
      if (lo !== e_bl) begin bad++; $display("FAIL divs_min_lo got=%h exp=%h", lo, e_bl); end
      if (hi !== e_bh) begin bad++; $display("FAIL divs_min_hi got=%h exp=%h", hi, e_bh); end
   endtask

   task automatic test_flush;
      int lat, sc; logic [15:0] lo, hi; logic [3:0] wo; logic sp, sd;
      int seen;
      do_op(2'b00, 16'h0003, 16'h0007, 4'h6, lat, lo, hi, wo, sp, sc, sd);
      total += 2;
      if (lo !== 16'h0015) begin bad++; $display("FAIL pre_flush_lo got=%h exp=0015", lo); end
      if (hi !== 16'h0000) begin bad++; $display("FAIL pre_flush_hi got=%h exp=0000", hi); end
      @(negedge clk);
      start = 1'b1; op = 2'b00; op1 = 16'h00FF; op2 = 16'h00FF; wreg_addr_i = 4'h7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      total += 4;
      if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
      if (result_lo !== 16'h0015) begin bad++; $display("FAIL flush_lo got=%h exp=0015", result_lo); end
      if (result_hi !== 16'h0000) begin bad++; $display("FAIL flush_hi got=%h exp=0000", result_hi); end
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) seen++;
      end
      if (seen !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
      // start together with flush in IDLE must be dropped
      start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL idle_flush_busy got=%b exp=0", busy); end
      @(negedge clk);
      do_op(2'b00, 16'h00FF, 16'h00FF, 4'h7, lat, lo, hi, wo, sp, sc, sd);
      total += 3;
      if (lat !== 17) begin bad++; $display("FAIL post_flush_lat got=%0d exp=17", lat); end
      if (lo !== 16'hFE01) begin bad++; $display("FAIL post_flush_lo got=%h exp=fe01", lo); end
      if (wo !== 4'h7) begin bad++; $display("FAIL post_flush_wa got=%h exp=7", wo); end
   endtask

   task automatic test_reset_mid;
      int lat, sc; logic [15:0] lo, hi; logic [3:0] wo; logic sp, sd;
      @(negedge clk);
      start = 1'b1; op = 2'b01; op1 = 16'd1000; op2 = 16'd3; wreg_addr_i = 4'hA;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total += 6;
      if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b exp=0", busy); end
      if (stall !== 1'b0) begin bad++; $display("FAIL mrst_stall got=%b exp=0", stall); end
      if (done !== 1'b0) begin bad++; $display("FAIL mrst_done got=%b exp=0", done); end
      if (result_lo !== 16'h0) begin bad++; $display("FAIL mrst_lo got=%h exp=0000", result_lo); end
      if (result_hi !== 16'h0) begin bad++; $display("FAIL mrst_hi got=%h exp=0000", result_hi); end
      if (wreg_addr_o !== 4'h0) begin bad++; $display("FAIL mrst_wa got=%h exp=0", wreg_addr_o); end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(2'b01, 16'd1000, 16'd3, 4'hA, lat, lo, hi, wo, sp, sc, sd);
      total += 3;
      if (lat !== 17) begin bad++; $display("FAIL mrst_lat got=%0d exp=17", lat); end
      if (lo !== 16'd333) begin bad++; $display("FAIL mrst_q got=%h exp=014d", lo); end
      if (hi !== 16'd1) begin bad++; $display("FAIL mrst_r got=%h exp=0001", hi); end
   endtask

   task automatic test_back_to_back;
      int lat, sc; logic [15:0] lo, hi; logic [3:0] wo; logic sp, sd;
      do_op(2'b00, 16'h0100, 16'h0100, 4'hE, lat, lo, hi, wo, sp, sc, sd);
      total += 2;
      if (hi !== 16'h0001) begin bad++; $display("FAIL b2b1_hi got=%h exp=0001", hi); end
      if (lo !== 16'h0000) begin bad++; $display("FAIL b2b1_lo got=%h exp=0000", lo); end
      do_op(2'b01, 16'd50, 16'd8, 4'hF, lat, lo, hi, wo, sp, sc, sd);
      total += 4;
      if (lat !== 17) begin bad++; $display("FAIL b2b2_lat got=%0d exp=17", lat); end
      if (lo !== 16'd6) begin bad++; $display("FAIL b2b2_lo got=%h exp=0006", lo); end
      if (hi !== 16'd2) begin bad++; $display("FAIL b2b2_hi got=%h exp=0002", hi); end
      if (wo !== 4'hF) begin bad++; $display("FAIL b2b2_wa got=%h exp=f", wo); end
   endtask

   initial begin
      start = 1'b0; op = 2'b00; op1 = 16'h0; op2 = 16'h0;
      wreg_addr_i = 4'h0; flush = 1'b0; rst_n = 1'b0;
      test_reset();
      test_mulu();
      test_divu();
      test_divzero();
      test_signed();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
